// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory-port arbiter: FSM state encoding, bus and
// command widths, the buffered-store record and the round-robin pick helper.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int XLEN   = 32;
  // One buffered store: address plus data.
  localparam int CMD_W  = ADDR_W + XLEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IRD  = 2'd1,
    ST_DRD  = 2'd2,
    ST_WR   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wcmd_t;

  // Class-level round robin. After an instruction read the other classes go
  // first (W, D, I); otherwise instruction fetch leads (I, W, D). W and D are
  // mutually exclusive by construction, so their relative order never matters.
  function automatic arb_state_t rr_pick(input logic last_i,
                                         input logic el_i,
                                         input logic el_w,
                                         input logic el_d);
    arb_state_t pick;
    pick = ST_IDLE;
    if (last_i) begin
      if (el_w)      pick = ST_WR;
      else if (el_d) pick = ST_DRD;
      else if (el_i) pick = ST_IRD;
    end else begin
      if (el_i)      pick = ST_IRD;
      else if (el_w) pick = ST_WR;
      else if (el_d) pick = ST_DRD;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the core-side request ports and the external memory port of the
// arbiter.
//   i_iread_en/i_iaddr, o_iread_vd/o_inst      : instruction-fetch miss port
//   i_read_en/i_write_en/i_memaddr/i_write_data: data port (loads, stores)
//   o_read_vd/o_read_data                      : load return
//   o_wbuf_full/o_wbuf_ovf                     : posted write buffer status
//   o_mem_*/i_mem_ack/i_mem_rdata              : external memory port
// slave  : the arbiter side (drives the o_* signals)
// master : the core + memory side (drives the i_* signals)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_iread_en;
  logic [ADDR_W-1:0] i_iaddr;
  logic              o_iread_vd;
  logic [XLEN-1:0]   o_inst;

  logic              i_read_en;
  logic              i_write_en;
  logic [ADDR_W-1:0] i_memaddr;
  logic [XLEN-1:0]   i_write_data;
  logic              o_read_vd;
  logic [XLEN-1:0]   o_read_data;

  logic              o_wbuf_full;
  logic              o_wbuf_ovf;

  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [XLEN-1:0]   o_mem_wdata;
  logic              i_mem_ack;
  logic [XLEN-1:0]   i_mem_rdata;

  modport slave (
    input  i_iread_en, i_iaddr,
    input  i_read_en, i_write_en, i_memaddr, i_write_data,
    input  i_mem_ack, i_mem_rdata,
    output o_iread_vd, o_inst, o_read_vd, o_read_data,
    output o_wbuf_full, o_wbuf_ovf,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_iread_en, i_iaddr,
    output i_read_en, i_write_en, i_memaddr, i_write_data,
    output i_mem_ack, i_mem_rdata,
    input  o_iread_vd, o_inst, o_read_vd, o_read_data,
    input  o_wbuf_full, o_wbuf_ovf,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
// Posted write buffer: a power-of-two deep FIFO whose head is always visible.
// A write is accepted when there is room, or when the buffer is full but the
// head leaves in the same cycle.
//   clk, rst   : clock, synchronous active-high reset (pointers and count)
//   wr_en_i    : write request, wr_data_i: entry to store
//   rd_en_i    : pop request (ignored when empty)
//   push_o     : write accepted this cycle
//   pop_o      : head removed this cycle
//   full_o     : count == DEPTH, empty_o: count == 0
//   count_o    : registered occupancy
//   head_o     : oldest entry
// -----------------------------------------------------------------------------
module wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic                     push_o,
  output logic                     pop_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign pop_o   = rd_en_i && !empty_o;
  // A pop in the same cycle frees the slot the incoming entry needs.
  assign push_o  = wr_en_i && (!full_o || pop_o);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_o) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_o)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_o, pop_o})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_o) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one 32-bit external memory port between the instruction-fetch miss
// port and the data port. Stores are posted into a write buffer; instruction
// reads, buffered writes and data reads are granted round-robin by class.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying the core request/response ports,
//              write-buffer status and the external memory request port.
// One transaction at a time: a grant in IDLE drives a registered request that
// holds until i_mem_ack, then the FSM returns to IDLE for at least one cycle.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  arb_state_t        state_q, state_d;
  logic              last_i_q, last_i_d;
  logic              ivd_q, ivd_d;
  logic              dvd_q, dvd_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              ovf_q, ovf_d;

  wcmd_t             wb_in;
  wcmd_t             wb_head;
  logic              wb_push;
  logic              wb_pop;
  logic              wb_full;
  logic              wb_empty;
  logic [CNT_W-1:0]  wb_count;

  logic              el_i, el_w, el_d;
  arb_state_t        grant;

  assign wb_in = '{addr: bus.i_memaddr, data: bus.i_write_data};

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (CMD_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bus.i_write_en),
    .wr_data_i (wb_in),
    .rd_en_i   ((state_q == ST_WR) && bus.i_mem_ack),
    .push_o    (wb_push),
    .pop_o     (wb_pop),
    .full_o    (wb_full),
    .empty_o   (wb_empty),
    .count_o   (wb_count),
    .head_o    (wb_head)
  );

  // A requester is masked during its own vd pulse: its cache hit only drops
  // the request one cycle later.
  assign el_i = bus.i_iread_en && !ivd_q;
  assign el_w = !wb_empty;
  // Loads wait until no store is buffered or landing this cycle, which gives
  // read-after-write ordering without address compare or forwarding.
  assign el_d = bus.i_read_en && !dvd_q && (wb_count == '0) && !wb_push;

  assign grant = rr_pick(last_i_q, el_i, el_w, el_d);

  always_comb begin
    state_d  = state_q;
    last_i_d = last_i_q;
    ivd_d    = 1'b0;
    dvd_d    = 1'b0;
    inst_d   = inst_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ovf_d    = ovf_q | (bus.i_write_en && !wb_push);

    case (state_q)
      ST_IDLE: begin
        // i_mem_ack is ignored here.
        state_d = grant;
        case (grant)
          ST_IRD: begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = bus.i_iaddr;
            wdata_d = '0;
          end
          ST_DRD: begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = bus.i_memaddr;
            wdata_d = '0;
          end
          ST_WR: begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = wb_head.addr;
            wdata_d = wb_head.data;
          end
          default: begin
            req_d = 1'b0;
          end
        endcase
      end

      ST_IRD: begin
        if (bus.i_mem_ack) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
          inst_d   = bus.i_mem_rdata;
          ivd_d    = 1'b1;
          last_i_d = 1'b1;
        end
      end

      ST_DRD: begin
        if (bus.i_mem_ack) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
          rdata_d  = bus.i_mem_rdata;
          dvd_d    = 1'b1;
          last_i_d = 1'b0;
        end
      end

      ST_WR: begin
        // The ack pops the buffer head in this same edge.
        if (wb_pop) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
          last_i_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset abandons any in-flight transaction; the request drops next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_i_q <= 1'b0;
      ivd_q    <= 1'b0;
      dvd_q    <= 1'b0;
      inst_q   <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_i_q <= last_i_d;
      ivd_q    <= ivd_d;
      dvd_q    <= dvd_d;
      inst_q   <= inst_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.o_iread_vd  = ivd_q;
  assign bus.o_inst      = inst_q;
  assign bus.o_read_vd   = dvd_q;
  assign bus.o_read_data = rdata_q;
  assign bus.o_wbuf_full = wb_full;
  assign bus.o_wbuf_ovf  = ovf_q;
  assign bus.o_mem_req   = req_q;
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.WBUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        is_i;
    logic [31:0] data;
  } rsp_t;

  txn_t txn_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  bit   ack_en;
  int   age;
  logic prev_req = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void exp_txn(input logic we, input logic [31:0] a,
                                  input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    txn_q.push_back(t);
  endfunction

  function automatic void exp_rsp(input logic is_i, input logic [31:0] d);
    rsp_t r;
    r.is_i = is_i; r.data = d;
    rsp_q.push_back(r);
  endfunction

  // Memory model: acks in the third cycle a request is visible.
  initial begin
    age = 0;
    forever begin
      @(negedge clk);
      if (ack_en) begin
        bus.i_mem_ack = 1'b0;
        if (bus.o_mem_req) begin
          age++;
          if (age == 3) begin
            bus.i_mem_ack = 1'b1;
            if (bus.o_mem_we) mem[bus.o_mem_addr] = bus.o_mem_wdata;
            else bus.i_mem_rdata = mem.exists(bus.o_mem_addr) ?
                                   mem[bus.o_mem_addr] : 32'hBAD0BAD0;
            age = 0;
          end
        end else begin
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: new memory requests and read returns against the scoreboard.
  always @(negedge clk) begin
    if (bus.o_mem_req && !prev_req) begin
      if (txn_q.size() == 0) begin
        chk("unexpected_req_addr", bus.o_mem_addr, 32'hFFFFFFFF);
      end else begin
        txn_t t;
        t = txn_q.pop_front();
        chk("req_we", {31'd0, bus.o_mem_we}, {31'd0, t.we});
        chk("req_addr", bus.o_mem_addr, t.addr);
        chk("req_wdata", bus.o_mem_wdata, t.wdata);
      end
    end
    prev_req <= bus.o_mem_req;
    if (bus.o_iread_vd) begin
      if (rsp_q.size() == 0) chk("unexpected_ivd", bus.o_inst, 32'hFFFFFFFF);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("ivd_class", {31'd0, r.is_i}, 32'd1);
        chk("inst_data", bus.o_inst, r.data);
      end
    end
    if (bus.o_read_vd) begin
      if (rsp_q.size() == 0) chk("unexpected_dvd", bus.o_read_data, 32'hFFFFFFFF);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("dvd_class", {31'd0, r.is_i}, 32'd0);
        chk("read_data", bus.o_read_data, r.data);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   {31'd0, bus.o_mem_req},   32'd0);
    chk({tag, "_we"},    {31'd0, bus.o_mem_we},    32'd0);
    chk({tag, "_addr"},  bus.o_mem_addr,           32'd0);
    chk({tag, "_wdata"}, bus.o_mem_wdata,          32'd0);
    chk({tag, "_ivd"},   {31'd0, bus.o_iread_vd},  32'd0);
    chk({tag, "_inst"},  bus.o_inst,               32'd0);
    chk({tag, "_dvd"},   {31'd0, bus.o_read_vd},   32'd0);
    chk({tag, "_rdata"}, bus.o_read_data,          32'd0);
    chk({tag, "_full"},  {31'd0, bus.o_wbuf_full}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, bus.o_wbuf_ovf},  32'd0);
  endtask

  // Waits (bounded) for a vd pulse; returns at the negedge where it is seen.
  task automatic wait_vd(input bit is_i, input string tag);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = is_i ? bus.o_iread_vd : bus.o_read_vd;
    end
    chk({tag, "_vd_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((txn_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, txn_q.size() + rsp_q.size(), 32'd0);
  endtask

  initial begin
    int n_vd;
    rst = 1'b1;
    ack_en = 1'b1;
    bus.i_iread_en = 0; bus.i_iaddr = 0;
    bus.i_read_en = 0; bus.i_write_en = 0;
    bus.i_memaddr = 0; bus.i_write_data = 0;
    bus.i_mem_ack = 0; bus.i_mem_rdata = 0;
    mem[32'h100] = 32'h00000013;
    mem[32'h300] = 32'h11111111;
    mem[32'h400] = 32'h22222222;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Instruction read: cycle 0 request, req at 1, ack at 3, vd at 4.
    @(negedge clk);
    bus.i_iread_en = 1; bus.i_iaddr = 32'h100;
    exp_txn(0, 32'h100, 0);
    exp_rsp(1, 32'h00000013);
    @(negedge clk);
    chk("ird_req_c1", {31'd0, bus.o_mem_req}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("ird_vd_c3", {31'd0, bus.o_iread_vd}, 32'd0);
    @(negedge clk);
    chk("ird_vd_c4", {31'd0, bus.o_iread_vd}, 32'd1);
    chk("ird_inst_c4", bus.o_inst, 32'h00000013);
    @(negedge clk);
    bus.i_iread_en = 0;
    chk("ird_vd_c5", {31'd0, bus.o_iread_vd}, 32'd0);
    chk("ird_no_rereq", {31'd0, bus.o_mem_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("inst_holds", bus.o_inst, 32'h00000013);
    wait_drain("ird");

    // Store then load on the next cycle: WR must precede DRD.
    @(negedge clk);
    bus.i_write_en = 1; bus.i_memaddr = 32'h200; bus.i_write_data = 32'hDEADBEEF;
    exp_txn(1, 32'h200, 32'hDEADBEEF);
    exp_txn(0, 32'h200, 0);
    exp_rsp(0, 32'hDEADBEEF);
    @(negedge clk);
    bus.i_write_en = 0; bus.i_read_en = 1;
    chk("st_ld_req_c1", {31'd0, bus.o_mem_req}, 32'd0);
    wait_vd(0, "st_ld");
    @(negedge clk);
    bus.i_read_en = 0;
    wait_drain("st_ld");

    // Store and load in the same cycle: the load still waits for the store.
    @(negedge clk);
    bus.i_write_en = 1; bus.i_read_en = 1;
    bus.i_memaddr = 32'h204; bus.i_write_data = 32'hCAFEF00D;
    exp_txn(1, 32'h204, 32'hCAFEF00D);
    exp_txn(0, 32'h204, 0);
    exp_rsp(0, 32'hCAFEF00D);
    @(negedge clk);
    bus.i_write_en = 0;
    wait_vd(0, "st_ld_same");
    @(negedge clk);
    bus.i_read_en = 0;
    wait_drain("st_ld_same");

    // Fairness: I and D held together alternate IRD, DRD, IRD, DRD.
    @(negedge clk);
    bus.i_iread_en = 1; bus.i_iaddr = 32'h300;
    bus.i_read_en = 1; bus.i_memaddr = 32'h400;
    for (int k = 0; k < 2; k++) begin
      exp_txn(0, 32'h300, 0);
      exp_rsp(1, 32'h11111111);
      exp_txn(0, 32'h400, 0);
      exp_rsp(0, 32'h22222222);
    end
    n_vd = 0;
    for (int k = 0; k < 100 && n_vd < 4; k++) begin
      @(negedge clk);
      if (bus.o_iread_vd || bus.o_read_vd) n_vd++;
    end
    bus.i_iread_en = 0; bus.i_read_en = 0;
    chk("fair_vd_count", n_vd, 32'd4);
    wait_drain("fair");

    // Overflow: memory held off, five back-to-back stores.
    @(negedge clk);
    ack_en = 0; bus.i_mem_ack = 0;
    for (int k = 0; k < 4; k++)
      exp_txn(1, 32'h500 + 32'(4 * k), 32'hA0000000 + 32'(k));
    exp_txn(1, 32'h520, 32'hA0000005);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      chk($sformatf("ovf_full_c%0d", k), {31'd0, bus.o_wbuf_full},
          (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("ovf_flag_c%0d", k), {31'd0, bus.o_wbuf_ovf}, 32'd0);
      bus.i_write_en = 1;
      bus.i_memaddr = 32'h500 + 32'(4 * k);
      bus.i_write_data = 32'hA0000000 + 32'(k);
    end
    @(negedge clk);
    bus.i_write_en = 0;
    chk("ovf_set", {31'd0, bus.o_wbuf_ovf}, 32'd1);
    chk("ovf_full_hold", {31'd0, bus.o_wbuf_full}, 32'd1);
    chk("wr_req_held", {31'd0, bus.o_mem_req}, 32'd1);
    chk("wr_addr_held", bus.o_mem_addr, 32'h500);
    @(negedge clk);
    chk("ovf_sticky1", {31'd0, bus.o_wbuf_ovf}, 32'd1);
    // Store in the ack cycle while full: accepted, count stays at 4.
    @(negedge clk);
    bus.i_write_en = 1; bus.i_memaddr = 32'h520; bus.i_write_data = 32'hA0000005;
    bus.i_mem_ack = 1;
    @(negedge clk);
    bus.i_write_en = 0; bus.i_mem_ack = 0;
    ack_en = 1;
    chk("ack_push_full", {31'd0, bus.o_wbuf_full}, 32'd1);
    chk("ack_push_ovf", {31'd0, bus.o_wbuf_ovf}, 32'd1);
    wait_drain("ovf");
    @(negedge clk);
    chk("drained_full", {31'd0, bus.o_wbuf_full}, 32'd0);
    chk("ovf_sticky2", {31'd0, bus.o_wbuf_ovf}, 32'd1);

    // Reset during WR with three stores buffered.
    @(negedge clk);
    ack_en = 0; bus.i_mem_ack = 0;
    exp_txn(1, 32'h600, 32'hB0000000);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      bus.i_write_en = 1;
      bus.i_memaddr = 32'h600 + 32'(4 * k);
      bus.i_write_data = 32'hB0000000 + 32'(k);
    end
    @(negedge clk);
    bus.i_write_en = 0;
    chk("rst_wr_busy", {31'd0, bus.o_mem_req}, 32'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 0; ack_en = 1;
    bus.i_iread_en = 1; bus.i_iaddr = 32'h100;
    exp_txn(0, 32'h100, 0);
    exp_rsp(1, 32'h00000013);
    @(negedge clk);
    chk("post_rst_req", {31'd0, bus.o_mem_req}, 32'd1);
    chk("post_rst_we", {31'd0, bus.o_mem_we}, 32'd0);
    chk("post_rst_addr", bus.o_mem_addr, 32'h100);
    wait_vd(1, "post_rst");
    @(negedge clk);
    bus.i_iread_en = 0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", {31'd0, bus.o_mem_req}, 32'd0);
    wait_drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one external 32-bit memory port between the core's instruction-fetch miss port and its data port (loads, stores, vector unit accesses). Stores go into a posted write buffer so the core never stalls on a store unless the buffer is full. Instruction reads, buffered writes and data reads are arbitrated round-robin by class. The block sits between the core's `o_iaddr`/`o_memaddr` ports and the memory or bus.

## Interface
- `WBUF_DEPTH`, 4: write buffer entries (power of two, ≥2).
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_iread_en` in 1: instruction read request (level); held until `o_iread_vd`.
- `i_iaddr` in 32: instruction address.
- `o_iread_vd` out 1: one-cycle pulse, `o_inst` valid.
- `o_inst` out 32: fetched word; holds its last value otherwise.
- `i_read_en` in 1: data read request (level); held until `o_read_vd`.
- `i_write_en` in 1: one-cycle store strobe.
- `i_memaddr` in 32: data address.
- `i_write_data` in 32: store data.
- `o_read_vd` out 1: one-cycle pulse, `o_read_data` valid.
- `o_read_data` out 32: loaded word; holds its last value otherwise.
- `o_wbuf_full` out 1: buffer count == `WBUF_DEPTH`; the core ORs this into `i_exstall`.
- `o_wbuf_ovf` out 1: sticky, set when a store is dropped; cleared only by `rst`.
- `o_mem_req` out 1: memory request, held until ack.
- `o_mem_we` out 1: 1 = write.
- `o_mem_addr` out 32: memory address.
- `o_mem_wdata` out 32: memory write data.
- `i_mem_ack` in 1: one-cycle completion; `i_mem_rdata` is valid in that cycle for reads.
- `i_mem_rdata` in 32: memory read data.

## Operation
- **States:** IDLE, IRD, DRD, WR. `o_mem_req`, `o_mem_we`, `o_mem_addr` and `o_mem_wdata` are registered and constant for the whole of IRD/DRD/WR.
- **Eligibility, evaluated in IDLE only:**
  - I = `i_iread_en` && !`o_iread_vd`.
  - W = buffer not empty.
  - D = `i_read_en` && !`o_read_vd` && buffer empty, including the cycle a store is being pushed. This gives read-after-write ordering with no forwarding.
- **Masking:** a request is ignored in the cycle its own vd pulse is high, because the requester's cache hit deasserts the request one cycle later.
- **Round-robin:** a `last_i` flag is set when an IRD completes and cleared when a DRD or WR completes.
  - If `last_i`=1, priority is W, then D, then I; otherwise I, then W, then D.
  - W and D are never both eligible.
- **Transitions:**
  - IDLE to IRD, DRD or WR on grant.
  - Busy state to IDLE on `i_mem_ack`.
  - With no eligible request, IDLE stays.
- **Read completion:** `i_mem_rdata` is captured at the ack edge; `o_iread_vd` or `o_read_vd` is high for exactly the next cycle.
- **Write completion:** the buffer head is popped at the ack edge.
- **Write buffer:** FIFO of {addr, data}; the head feeds WR.
  - Push when `i_write_en` and (count < `WBUF_DEPTH` or a pop happens in the same cycle).
  - Otherwise the store is dropped and `o_wbuf_ovf` is set.
  - Pointers wrap modulo `WBUF_DEPTH`; count width is clog2(`WBUF_DEPTH`)+1.
- **`i_mem_ack` in IDLE** is ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, buffer empty, `last_i`=0 (I wins the first conflict).
- **Latency:** request sampled in IDLE at cycle 0; `o_mem_req` is high from cycle 1; ack at cycle k ≥ 1; vd at k+1; IDLE at k+1.
- **Spacing:** the earliest next `o_mem_req` is k+2, so there is at least one idle cycle between transactions.
- **Store acceptance:** a store is accepted in the cycle `i_write_en` is high. `o_wbuf_full` reflects the registered count and rises the cycle after the filling push.
- **Push and pop together:** a simultaneous push and pop at full leaves count unchanged, with no overflow.
- **Reset mid-transaction:** the transaction is abandoned, `o_mem_req` drops the next cycle and buffered stores are lost. The memory side must tolerate a request withdrawn before ack.

## Structure
- Shared package/header holds:
  - state encodings (IDLE=0, IRD=1, DRD=2, WR=3);
  - a command-width constant (64 = addr + data).
- One sub-module, `wbuf_fifo`:
  - parameterised by depth and width;
  - outputs push/pop/full/empty/count/head.
- The FSM and round-robin logic stay in `mem_arbiter`.

## Test plan
- **Instruction read:** `i_iread_en`, `i_iaddr`=0x100, memory acks 2 cycles after req with 0x00000013 → `o_mem_req` at cycle 1, `o_iread_vd` for one cycle at cycle 4 with `o_inst`=0x00000013, and no second request while `i_iread_en` stays high during the vd cycle.
- **Store then load:** store 0xDEADBEEF to 0x200, then load 0x200 in the next cycle → WR issued before DRD; `o_read_vd` returns the memory's value; DRD is not granted while the buffer is non-empty.
- **Fairness:** I and D held continuously with the buffer empty → memory sees the order IRD, DRD, IRD, DRD.
- **Overflow:** 5 back-to-back stores with `WBUF_DEPTH`=4 and memory never acking → `o_wbuf_full`=1 after the 4th; the 5th is dropped; `o_wbuf_ovf`=1 and sticky. A store in the ack cycle at full is accepted and count stays 4.
- **Reset mid-operation:** `rst` during WR with 3 entries buffered → next cycle all outputs are 0, count is 0 and state is IDLE. After release, an I request gets `o_mem_req` 1 cycle later.
